// File: rtl/pipemdu_pkg.sv
// pipemdu_pkg: opcodes, FSM state encoding and shared constants for the
// EXE-stage multiply/divide unit. The divider is built only when the
// PIPEMDU_DIV_EN macro is defined.
package pipemdu_pkg;

  // Iteration count of one multiply or divide (one bit per cycle).
  localparam int MDU_ITER = 32;

  // MDU opcodes presented on emdop by the ID/EXE register; 9..15 act as NONE.
  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } mdu_state_e;

  // Quotient for x/0 is every bit set; replicated to the operand width.
  localparam logic DIVZ_Q_FILL = 1'b1;

  // True for every opcode that touches HI/LO and therefore must wait
  // while an operation is in flight. Disabled-divider builds treat
  // DIV/DIVU as NONE, so they never stall.
  function automatic logic is_md_op(input logic [3:0] op);
    logic r;
    r = 1'b0;
    case (op)
      OP_MULT, OP_MULTU, OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO: r = 1'b1;
`ifdef PIPEMDU_DIV_EN
      OP_DIV, OP_DIVU: r = 1'b1;
`endif
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/pipemdu_if.sv
// pipemdu_if: EXE-side bundle between the ID/EXE register (master) and the
// multiply/divide unit (slave).
//
// Handshake: there is no valid/ready pair. A nonzero emdop is the request;
// it is accepted at the rising edge in which stall is low. While stall is
// high the unit ignores emdop and the pipeline holds and re-presents the
// same instruction every cycle until stall drops. mdres is meaningful only
// in cycles where stall is low.
interface pipemdu_if #(
  parameter int MDU_W = pipemdu_pkg::MDU_ITER
);
  logic [MDU_W-1:0] ea;
  logic [MDU_W-1:0] eb;
  logic [3:0]       emdop;
  logic             stall;
  logic             busy;
  logic [MDU_W-1:0] mdres;
  logic [MDU_W-1:0] hi;
  logic [MDU_W-1:0] lo;

  modport master (
    output ea, eb, emdop,
    input  stall, busy, mdres, hi, lo
  );

  modport slave (
    input  ea, eb, emdop,
    output stall, busy, mdres, hi, lo
  );
endinterface

// File: rtl/pipemdu_iter.sv
// pipemdu_iter: iterative datapath of the MDU. Holds the 2W-bit
// accumulator (product, or remainder:quotient), the operand register and
// the iteration counter, and performs one shift-add (multiply) or one
// restoring subtract (divide, only with PIPEMDU_DIV_EN) per step.
module pipemdu_iter
  import pipemdu_pkg::*;
#(
  parameter int W = MDU_ITER
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic         load,
`ifdef PIPEMDU_DIV_EN
  input  logic         is_div,
`endif
  input  logic         step,
  input  logic [W-1:0] acc_init,
  input  logic [W-1:0] opnd_init,
  output logic [W-1:0] acc_hi,
  output logic [W-1:0] acc_lo,
  output logic         last
);

  logic [W-1:0] hi_q, lo_q, opnd_q;
  logic [W-1:0] nxt_hi, nxt_lo;
  logic [W:0]   mul_sum;
  logic [5:0]   cnt_q;

`ifdef PIPEMDU_DIV_EN
  logic         div_q;
  logic [W:0]   shifted;
  logic [W:0]   diff;
`endif

  // One iteration: multiplier LSB selects the add, then shift right;
  // the divider shifts left and keeps the difference when it does not borrow.
  always_comb begin
    mul_sum = {1'b0, hi_q} + {1'b0, (lo_q[0] ? opnd_q : '0)};
    nxt_hi  = mul_sum[W:1];
    nxt_lo  = {mul_sum[0], lo_q[W-1:1]};
`ifdef PIPEMDU_DIV_EN
    shifted = {hi_q, lo_q[W-1]};
    diff    = shifted - {1'b0, opnd_q};
    if (div_q) begin
      nxt_hi = diff[W] ? shifted[W-1:0] : diff[W-1:0];
      nxt_lo = {lo_q[W-2:0], ~diff[W]};
    end
`endif
  end

  // Accumulator, operand and counter: cleared on load, advanced on step.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      hi_q   <= '0;
      lo_q   <= '0;
      opnd_q <= '0;
      cnt_q  <= '0;
    end else if (load) begin
      hi_q   <= '0;
      lo_q   <= acc_init;
      opnd_q <= opnd_init;
      cnt_q  <= '0;
    end else if (step) begin
      hi_q   <= nxt_hi;
      lo_q   <= nxt_lo;
      cnt_q  <= cnt_q + 6'd1;
    end
  end

`ifdef PIPEMDU_DIV_EN
  // Remember which algorithm this operation runs.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)   div_q <= 1'b0;
    else if (load) div_q <= is_div;
  end
`endif

  assign acc_hi = hi_q;
  assign acc_lo = lo_q;
  assign last   = (cnt_q == 6'(W - 1));

endmodule

// File: rtl/pipemdu.sv
// pipemdu: EXE-stage iterative multiply/divide unit with private HI/LO.
// Operations run in the background for 33 cycles; stall is raised only
// when a HI/LO-dependent instruction reaches EXE while busy.
// Optional divider: define PIPEMDU_DIV_EN to build DIV/DIVU.
module pipemdu
  import pipemdu_pkg::*;
#(
  parameter int MDU_W = MDU_ITER
) (
  input  logic       clock,
  input  logic       resetn,
  pipemdu_if.slave   bus,
  output logic [1:0] dbg_state
);

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_MUL  = ST_MUL;
`ifdef PIPEMDU_DIV_EN
  localparam logic [1:0] S_DIV  = ST_DIV;
`endif
  localparam logic [1:0] S_FIX  = ST_FIX;

  logic [1:0]       state;
  logic             op_mul, op_div, signed_op, sa, sb, load, step, last;
  logic [MDU_W-1:0] mag_a, mag_b, acc_init, opnd_init, acc_hi, acc_lo;
  logic [MDU_W-1:0] hi_q, lo_q, hi_fix, lo_fix;
  logic [2*MDU_W-1:0] prod_fix;
  logic             neg_res;
`ifdef PIPEMDU_DIV_EN
  logic             neg_rem, div_zero, res_div;
`endif

  assign op_mul    = (bus.emdop == OP_MULT) || (bus.emdop == OP_MULTU);
`ifdef PIPEMDU_DIV_EN
  assign op_div    = (bus.emdop == OP_DIV) || (bus.emdop == OP_DIVU);
`else
  assign op_div    = 1'b0;
`endif
  assign signed_op = (bus.emdop == OP_MULT) || (bus.emdop == OP_DIV);
  assign sa        = signed_op & bus.ea[MDU_W-1];
  assign sb        = signed_op & bus.eb[MDU_W-1];
  assign mag_a     = sa ? -bus.ea : bus.ea;
  assign mag_b     = sb ? -bus.eb : bus.eb;

  // Multiply shifts the multiplier through the low half; divide shifts the dividend.
  assign load      = (state == S_IDLE) && (op_mul || op_div);
  assign acc_init  = op_mul ? mag_b : mag_a;
  assign opnd_init = op_mul ? mag_a : mag_b;
`ifdef PIPEMDU_DIV_EN
  assign step      = (state == S_MUL) || (state == S_DIV);
`else
  assign step      = (state == S_MUL);
`endif

  pipemdu_iter #(.W(MDU_W)) u_iter (
    .clock     (clock),
    .resetn    (resetn),
    .load      (load),
`ifdef PIPEMDU_DIV_EN
    .is_div    (op_div),
`endif
    .step      (step),
    .acc_init  (acc_init),
    .opnd_init (opnd_init),
    .acc_hi    (acc_hi),
    .acc_lo    (acc_lo),
    .last      (last)
  );

  // Control FSM: issue from IDLE, iterate, then one FIX edge writes HI/LO.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (op_mul)      state <= S_MUL;
`ifdef PIPEMDU_DIV_EN
          else if (op_div) state <= S_DIV;
`endif
        end
        S_MUL:   if (last) state <= S_FIX;
`ifdef PIPEMDU_DIV_EN
        S_DIV:   if (last) state <= S_FIX;
`endif
        S_FIX:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Signs are captured at issue because ea/eb move on once the op is accepted.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      neg_res  <= 1'b0;
`ifdef PIPEMDU_DIV_EN
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      res_div  <= 1'b0;
`endif
    end else if (load) begin
      neg_res  <= sa ^ sb;
`ifdef PIPEMDU_DIV_EN
      neg_rem  <= sa;
      div_zero <= op_div && (bus.eb == '0);
      res_div  <= op_div;
`endif
    end
  end

  // Sign fix-up. x/0 forces an all-ones quotient; the remainder path
  // already reproduces the dividend because its sign is restored.
  always_comb begin
    prod_fix = neg_res ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
    hi_fix   = prod_fix[2*MDU_W-1:MDU_W];
    lo_fix   = prod_fix[MDU_W-1:0];
`ifdef PIPEMDU_DIV_EN
    if (res_div) begin
      hi_fix = neg_rem ? -acc_hi : acc_hi;
      if (div_zero)     lo_fix = {MDU_W{DIVZ_Q_FILL}};
      else if (neg_res) lo_fix = -acc_lo;
      else              lo_fix = acc_lo;
    end
`endif
  end

  // HI/LO: written by FIX, or by MTHI/MTLO accepted in IDLE.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (state == S_FIX) begin
      hi_q <= hi_fix;
      lo_q <= lo_fix;
    end else if (state == S_IDLE) begin
      if (bus.emdop == OP_MTHI) hi_q <= bus.ea;
      if (bus.emdop == OP_MTLO) lo_q <= bus.ea;
    end
  end

  // Move-from result reads the registers as they stand this cycle.
  always_comb begin
    bus.mdres = '0;
    if (bus.emdop == OP_MFHI)      bus.mdres = hi_q;
    else if (bus.emdop == OP_MFLO) bus.mdres = lo_q;
  end

  assign bus.busy  = (state != S_IDLE);
  assign bus.stall = bus.busy && is_md_op(bus.emdop);
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_pipemdu.sv
// tb_pipemdu: directed self-checking bench for pipemdu. Divider vectors
// are selected by PIPEMDU_DIV_EN, matching the RTL build.
module tb_pipemdu;
  import pipemdu_pkg::*;

  logic       clock;
  logic       resetn;
  logic [1:0] dbg_state;
  int         checks;
  int         failures;

  pipemdu_if #(.MDU_W(32)) bus ();

  pipemdu #(.MDU_W(32)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Clock and watchdog
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.emdop = op;
    bus.ea    = a;
    bus.eb    = b;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (bus.busy === 1'b1 && n < 200) begin
      n++;
      step();
    end
  endtask

  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int n);
    drive(op, a, b);
    step();
    drive(OP_NONE, 32'h0, 32'h0);
    wait_idle(n);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    drive(OP_MFHI, 32'h1234_5678, 32'h0);
    #12;
    checks++; if (bus.hi !== 32'h0) begin failures++; $display("FAIL reset_hi got=%h exp=%h", bus.hi, 32'h0); end
    checks++; if (bus.lo !== 32'h0) begin failures++; $display("FAIL reset_lo got=%h exp=%h", bus.lo, 32'h0); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", bus.stall); end
    checks++; if (bus.mdres !== 32'h0) begin failures++; $display("FAIL reset_mdres got=%h exp=%h", bus.mdres, 32'h0); end
    checks++; if (dbg_state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
    step();
    resetn = 1'b1;
    drive(OP_NONE, 32'h0, 32'h0);
    step();
  endtask

  task automatic test_mult_signed();
    int n;
    run_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, n);
    checks++; if (n !== 33) begin failures++; $display("FAIL mult_busy_cycles got=%0d exp=33", n); end
    checks++; if (bus.hi !== 32'hFFFF_FFFF) begin failures++; $display("FAIL mult_hi got=%h exp=%h", bus.hi, 32'hFFFF_FFFF); end
    checks++; if (bus.lo !== 32'hFFFF_FFEB) begin failures++; $display("FAIL mult_lo got=%h exp=%h", bus.lo, 32'hFFFF_FFEB); end
  endtask

  task automatic test_multu_stall();
    int n;
    drive(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    step();
    drive(OP_MFHI, 32'h0, 32'h0);
    #1;
    n = 0;
    while (bus.stall === 1'b1 && n < 200) begin
      n++;
      step();
    end
    checks++; if (n !== 33) begin failures++; $display("FAIL multu_stall_cycles got=%0d exp=33", n); end
    checks++; if (bus.mdres !== 32'hFFFF_FFFE) begin failures++; $display("FAIL multu_mfhi got=%h exp=%h", bus.mdres, 32'hFFFF_FFFE); end
    checks++; if (bus.lo !== 32'h0000_0001) begin failures++; $display("FAIL multu_lo got=%h exp=%h", bus.lo, 32'h1); end
    drive(OP_MFLO, 32'h0, 32'h0);
    #1;
    checks++; if (bus.mdres !== 32'h0000_0001) begin failures++; $display("FAIL multu_mflo got=%h exp=%h", bus.mdres, 32'h1); end
    drive(OP_NONE, 32'h0, 32'h0);
    #1;
    checks++; if (bus.mdres !== 32'h0) begin failures++; $display("FAIL none_mdres got=%h exp=0", bus.mdres); end
    step();
  endtask

  task automatic test_moves();
    drive(OP_MTHI, 32'h1234_5678, 32'h0);
    step();
    drive(OP_MFHI, 32'h0, 32'h0);
    #1;
    checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL mthi_stall got=%b exp=0", bus.stall); end
    checks++; if (bus.mdres !== 32'h1234_5678) begin failures++; $display("FAIL mthi_mfhi got=%h exp=%h", bus.mdres, 32'h1234_5678); end
    checks++; if (bus.lo !== 32'h0000_0001) begin failures++; $display("FAIL mthi_lo_kept got=%h exp=%h", bus.lo, 32'h1); end
    drive(OP_MTLO, 32'hCAFE_F00D, 32'h0);
    step();
    drive(OP_MFLO, 32'h0, 32'h0);
    #1;
    checks++; if (bus.mdres !== 32'hCAFE_F00D) begin failures++; $display("FAIL mtlo_mflo got=%h exp=%h", bus.mdres, 32'hCAFE_F00D); end
    checks++; if (bus.hi !== 32'h1234_5678) begin failures++; $display("FAIL mtlo_hi_kept got=%h exp=%h", bus.hi, 32'h1234_5678); end
    drive(OP_NONE, 32'h0, 32'h0);
    step();
  endtask

  task automatic test_back_to_back();
    int n;
    drive(OP_MULT, 32'd2, 32'd3);
    step();
    drive(OP_MULT, 32'd4, 32'd5);
    #1;
    n = 0;
    while (bus.stall === 1'b1 && n < 200) begin
      n++;
      step();
    end
    checks++; if (n !== 33) begin failures++; $display("FAIL b2b_stall_cycles got=%0d exp=33", n); end
    checks++; if (bus.lo !== 32'd6) begin failures++; $display("FAIL b2b_first_lo got=%h exp=%h", bus.lo, 32'd6); end
    step();
    drive(OP_NONE, 32'h0, 32'h0);
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL b2b_second_issue got=%b exp=1", bus.busy); end
    wait_idle(n);
    checks++; if (n !== 33) begin failures++; $display("FAIL b2b_second_cycles got=%0d exp=33", n); end
    checks++; if (bus.lo !== 32'd20) begin failures++; $display("FAIL b2b_second_lo got=%h exp=%h", bus.lo, 32'd20); end
    checks++; if (bus.hi !== 32'd0) begin failures++; $display("FAIL b2b_second_hi got=%h exp=0", bus.hi); end
  endtask

`ifdef PIPEMDU_DIV_EN
  task automatic test_divide();
    logic [3:0]  t_op[6];
    logic [31:0] t_a[6], t_b[6], t_lo[6], t_hi[6];
    int n;
    t_op[0] = OP_DIV;  t_a[0] = 32'hFFFF_FFF9; t_b[0] = 32'd2;         t_lo[0] = 32'hFFFF_FFFD; t_hi[0] = 32'hFFFF_FFFF;
    t_op[1] = OP_DIVU; t_a[1] = 32'd7;         t_b[1] = 32'd0;         t_lo[1] = 32'hFFFF_FFFF; t_hi[1] = 32'd7;
    t_op[2] = OP_DIV;  t_a[2] = 32'h8000_0000; t_b[2] = 32'hFFFF_FFFF; t_lo[2] = 32'h8000_0000; t_hi[2] = 32'd0;
    t_op[3] = OP_DIV;  t_a[3] = 32'hFFFF_FFF9; t_b[3] = 32'd0;         t_lo[3] = 32'hFFFF_FFFF; t_hi[3] = 32'hFFFF_FFF9;
    t_op[4] = OP_DIVU; t_a[4] = 32'd100;       t_b[4] = 32'd7;         t_lo[4] = 32'd14;        t_hi[4] = 32'd2;
    t_op[5] = OP_DIV;  t_a[5] = 32'd7;         t_b[5] = 32'hFFFF_FFFE; t_lo[5] = 32'hFFFF_FFFD; t_hi[5] = 32'd1;
    for (int i = 0; i < 6; i++) begin
      run_op(t_op[i], t_a[i], t_b[i], n);
      checks++; if (n !== 33) begin failures++; $display("FAIL div%0d_cycles got=%0d exp=33", i, n); end
      checks++; if (bus.lo !== t_lo[i]) begin failures++; $display("FAIL div%0d_lo got=%h exp=%h", i, bus.lo, t_lo[i]); end
      checks++; if (bus.hi !== t_hi[i]) begin failures++; $display("FAIL div%0d_hi got=%h exp=%h", i, bus.hi, t_hi[i]); end
    end
  endtask
`else
  task automatic test_div_disabled();
    drive(OP_MTHI, 32'hAAAA_5555, 32'h0);
    step();
    drive(OP_MTLO, 32'h0F0F_0F0F, 32'h0);
    step();
    drive(OP_DIV, 32'd9, 32'd3);
    #1;
    checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL nodiv_stall got=%b exp=0", bus.stall); end
    step();
    drive(OP_DIVU, 32'd9, 32'd3);
    step();
    drive(OP_NONE, 32'h0, 32'h0);
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL nodiv_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.hi !== 32'hAAAA_5555) begin failures++; $display("FAIL nodiv_hi got=%h exp=%h", bus.hi, 32'hAAAA_5555); end
    checks++; if (bus.lo !== 32'h0F0F_0F0F) begin failures++; $display("FAIL nodiv_lo got=%h exp=%h", bus.lo, 32'h0F0F_0F0F); end
    // A disabled DIV presented while a multiply runs must not stall.
    drive(OP_MULT, 32'd3, 32'd3);
    step();
    drive(OP_DIV, 32'd9, 32'd3);
    #1;
    checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL nodiv_busy_stall got=%b exp=0", bus.stall); end
    drive(OP_NONE, 32'h0, 32'h0);
    begin
      int n;
      wait_idle(n);
      checks++; if (bus.lo !== 32'd9) begin failures++; $display("FAIL nodiv_mult_lo got=%h exp=%h", bus.lo, 32'd9); end
    end
  endtask
`endif

  task automatic test_reset_mid();
    int n;
    drive(OP_MTHI, 32'h1111_1111, 32'h0);
    step();
    drive(OP_MTLO, 32'h2222_2222, 32'h0);
    step();
`ifdef PIPEMDU_DIV_EN
    drive(OP_DIVU, 32'hFFFF_0000, 32'd3);
`else
    drive(OP_MULT, 32'hFFFF_0000, 32'd3);
`endif
    step();
    drive(OP_NONE, 32'h0, 32'h0);
    repeat (9) step();
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL rstmid_busy_before got=%b exp=1", bus.busy); end
    resetn = 1'b0;
    #1;
    checks++; if (bus.hi !== 32'h0) begin failures++; $display("FAIL rstmid_hi got=%h exp=0", bus.hi); end
    checks++; if (bus.lo !== 32'h0) begin failures++; $display("FAIL rstmid_lo got=%h exp=0", bus.lo); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", bus.busy); end
    checks++; if (dbg_state !== 2'd0) begin failures++; $display("FAIL rstmid_state got=%0d exp=0", dbg_state); end
    step();
    resetn = 1'b1;
    step();
    run_op(OP_MULT, 32'd5, 32'd6, n);
    checks++; if (n !== 33) begin failures++; $display("FAIL rstmid_mult_cycles got=%0d exp=33", n); end
    checks++; if (bus.lo !== 32'd30) begin failures++; $display("FAIL rstmid_mult_lo got=%h exp=%h", bus.lo, 32'd30); end
    checks++; if (bus.hi !== 32'd0) begin failures++; $display("FAIL rstmid_mult_hi got=%h exp=0", bus.hi); end
  endtask

  // Test sequence and final report
  initial begin
    checks   = 0;
    failures = 0;
    resetn   = 1'b0;
    drive(OP_NONE, 32'h0, 32'h0);
    test_reset();
    test_mult_signed();
    test_multu_stall();
    test_moves();
    test_back_to_back();
`ifdef PIPEMDU_DIV_EN
    test_divide();
`else
    test_div_disabled();
`endif
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
